// File: rtl/bus_req_pkg.sv
// Shared types for the per-master bus request controller: FSM states,
// default field widths and the queued burst command format.
package bus_req_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } bus_req_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [LEN_W_DEF-1:0]  len;
    } bus_req_cmd_t;

endpackage

// File: rtl/bus_req_fifo.sv
// Command FIFO for bus_req_ctrl; count includes the entry currently being
// transferred because the head is only popped on the final beat.
module bus_req_fifo
    import bus_req_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  bus_req_cmd_t     wr_data,
    input  logic             pop,
    output bus_req_cmd_t     rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    bus_req_cmd_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/bus_req_ctrl.sv
// Per-master request controller: queues burst commands, requests the bus,
// streams beats while granted and releases req for one cycle after each burst.
// Define BUS_REQ_TIMEOUT_EN to enable the sticky grant-wait timeout flag.
module bus_req_ctrl
    import bus_req_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     req,
    input  logic                     gnt,
    output logic                     bus_valid,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic                     bus_last,
    input  logic                     bus_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     timeout_err
);

    bus_req_state_e   state;
    bus_req_state_e   next_state;
    bus_req_cmd_t     wr_cmd;
    bus_req_cmd_t     head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             beat_ok;
    logic [LEN_W-1:0] beat_cnt;
    logic [ADDR_W-1:0] addr;

    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign wr_cmd    = {cmd_addr, cmd_len};
    assign beat_ok   = bus_valid && bus_ready;
    assign pop       = beat_ok && bus_last;

    bus_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (!empty) next_state = REQ;
            REQ:  if (gnt) next_state = XFER;
            XFER: begin
                if (pop)       next_state = REL;
                else if (!gnt) next_state = REQ;
            end
            REL:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // req is a pure state decode so reset removes it without waiting for a clock.
    always_comb begin
        req       = 1'b0;
        bus_valid = 1'b0;
        case (state)
            REQ:  req = 1'b1;
            XFER: begin
                req       = 1'b1;
                bus_valid = gnt;
            end
            default: ;
        endcase
        bus_last = bus_valid && (beat_cnt == '0);
    end

    // Loading only on leaving IDLE lets a burst resume mid-way after a lost grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            addr     <= '0;
        end else if (state == IDLE && !empty) begin
            beat_cnt <= head.len;
            addr     <= head.addr;
        end else if (beat_ok) begin
            addr <= addr + 1'b1;
            if (beat_cnt != '0) beat_cnt <= beat_cnt - 1'b1;
        end
    end

    assign bus_addr = addr;

`ifdef BUS_REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == REQ) begin
            if (to_cnt != TO_W'(TIMEOUT_CYC)) to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) timeout_err <= 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: doc/bus_req_ctrl.md
# bus_req_ctrl

Per-master request controller sitting directly upstream of the 4-way round-robin arbiter: one instance drives each `reqN`/`gntN` pair. It buffers burst commands from its master, raises `req`, waits for the registered grant, streams the burst beats onto the shared bus, then drops `req` for exactly one cycle so the arbiter rotates priority to the next requester.

## Interface
- `ADDR_W`, 16: bus address width.
- `LEN_W`, 4: burst length field width; a command carries beats-minus-1.
- `DEPTH`, 4: command FIFO depth, power of two, ≥2.
- `TIMEOUT_CYC`, 64: grant-wait limit; used only with `BUS_REQ_TIMEOUT_EN`.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous active-high reset.
- `cmd_valid` in 1: command offered by master.
- `cmd_ready` out 1: FIFO not full.
- `cmd_addr` in ADDR_W: burst start address.
- `cmd_len` in LEN_W: beats − 1.
- `req` out 1: to arbiter `reqN`.
- `gnt` in 1: from arbiter `gntN`, registered in the arbiter.
- `bus_valid` out 1: beat valid on shared bus.
- `bus_addr` out ADDR_W: beat address.
- `bus_last` out 1: final beat of burst.
- `bus_ready` in 1: slave accepts beat.
- `fifo_count` out $clog2(DEPTH)+1: queued commands, including the one in flight.
- `timeout_err` out 1: sticky grant-timeout flag.

## Operation
- FIFO: push on `cmd_valid & cmd_ready`. `cmd_ready = !full`, with no bypass. Pop happens on the last-beat handshake. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, REQ, XFER, REL.
  - IDLE: if FIFO is non-empty, go to REQ. Any `gnt` seen in IDLE is ignored.
  - REQ: `req=1`. When `gnt=1` at an edge, go to XFER. On the first entry for a command, load beat counter = `cmd_len` and address = `cmd_addr` from the FIFO head.
  - XFER: `req=1`, `bus_valid = gnt`.
    - Each `bus_valid & bus_ready` decrements the counter and increments the address modulo 2^ADDR_W.
    - `bus_last = bus_valid & (counter==0)`.
    - When the last beat is accepted: pop the FIFO and go to REL.
    - If `gnt=0` at an edge: go to REQ, retaining the counter and address, and resume from the same beat when the grant returns.
  - REL: `req=0`, `bus_valid=0` (the arbiter still shows `gnt` this cycle). Always go to IDLE next.
- `req = (state==REQ) | (state==XFER)`. This is a decode of registered state and has no combinational path from any input.
- Beats per burst = `cmd_len+1`. `cmd_len=0` gives one beat; the maximum is 2^LEN_W.
- `bus_valid` stays asserted while `bus_ready=0`, with address and last held stable.

## Timing
- Reset, asynchronous and immediate: state IDLE, FIFO empty, `fifo_count=0`, `req=0`, `bus_valid=0`, `bus_last=0`, `bus_addr=0`, `timeout_err=0`, `cmd_ready=0` while `rst` is high. `cmd_ready` is 1 from the first cycle after release.
- `req` drops asynchronously on reset mid-burst. The partial burst is discarded.
- Command accepted at edge N:
  - IDLE→REQ at N+1, `req` high after N+1.
  - Arbiter samples at N+2, `gnt` high after N+2.
  - REQ→XFER at N+3, first beat offered after N+3.
- With `bus_ready` held high, a burst of L+1 beats occupies L+1 cycles in XFER, then one REL cycle, then one IDLE cycle.
- Back-to-back commands: minimum `req` low time is REL + IDLE = 2 cycles. The arbiter therefore always sees `req=0` for at least one edge and re-arbitrates.

## Configuration
- `BUS_REQ_TIMEOUT_EN` defined:
  - A counter runs while in REQ and clears on leaving REQ.
  - Reaching `TIMEOUT_CYC` sets `timeout_err`. It is cleared only by `rst`.
  - The FSM keeps waiting for the grant regardless.
- `BUS_REQ_TIMEOUT_EN` undefined: no counter logic; `timeout_err` is tied to 0.

## Structure
- Package `bus_req_pkg` holds:
  - the state enum `bus_req_state_e` (IDLE, REQ, XFER, REL);
  - default width constants for ADDR_W and LEN_W;
  - the packed command struct `bus_req_cmd_t` {addr, len}.
- Sub-module `bus_req_fifo`: a synchronous FIFO of `bus_req_cmd_t`, DEPTH entries, asynchronous active-high reset, with full/empty/count outputs.
- `bus_req_ctrl` holds the FSM, the beat counter, the address register and the optional timeout counter.

## Test plan
- Single beat: cmd addr=0x0010, len=0 at edge N, `gnt` tied to `req` delayed one cycle, `bus_ready=1` -> exactly one beat, addr 0x0010 with `bus_last=1`, starting after N+3; `req` low after the REL edge; `fifo_count` returns to 0.
- Burst with backpressure: len=3, addr=0xFFFE, `bus_ready` toggling 1/0 -> beats 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap), each held stable while not ready; `bus_last` only on 0x0001.
- Full FIFO: push 4 commands while `gnt=0` -> `cmd_ready=0` and `fifo_count=4`; grant then drains all four; `req` is low ≥1 edge between bursts.
- Grant loss: len=5, `gnt` forced low after beat 2 for 3 cycles -> `bus_valid=0` during the gap; resumes at beat 3 with the correct address; 6 beats total.
- Reset mid-burst: assert `rst` between edges during beat 1 of len=7 -> `req`/`bus_valid` low immediately; `fifo_count=0`; `cmd_ready=1` after release.
- Timeout (macro on, TIMEOUT_CYC=8): command queued, `gnt` held 0 -> `timeout_err` rises 8 cycles after REQ entry and stays set after a grant arrives; with the macro off it stays 0.
